// File: rtl/transpose_stream.sv
// transpose_stream: ping-pong tile buffer that streams NUM_PE x NUM_PE tiles
// either transposed or unchanged. Rows are written into one bank while the
// other bank is drained one beat per cycle; the two banks swap roles each time
// a tile is completed on either side.

module transpose_stream_checker (
   input logic clk,
   input logic rst,
   input logic in_ready,
   input logic out_valid,
   input logic out_last,
   input logic busy,
   input logic both_full_s
);

   // out_last only ever marks a beat that is actually being presented
   a_last_needs_valid : assert property (@(posedge clk) disable iff (!rst)
      out_last |-> out_valid);

   // with both banks holding complete tiles there is nowhere to put a new row
   a_full_blocks_input : assert property (@(posedge clk) disable iff (!rst)
      both_full_s |-> !in_ready);

   // a presented beat always comes from a non-empty bank
   a_valid_implies_busy : assert property (@(posedge clk) disable iff (!rst)
      out_valid |-> busy);

endmodule

module transpose_stream #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_PE     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mode,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_PE*DATA_WIDTH-1:0] in_row,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_PE*DATA_WIDTH-1:0] out_row,
   output logic                         out_last,
   output logic                         busy
);

   localparam int ROW_W = NUM_PE * DATA_WIDTH;
   localparam int CW    = $clog2(NUM_PE);
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PE - 1);
   localparam logic [CW-1:0] ZERO_IDX = CW'(1'b0);
   localparam logic [CW-1:0] ONE_IDX  = CW'(1'b1);

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

   // control state
   bank_state_e bank_state_q [2];
   bank_state_e bank_state_d [2];
   logic [1:0]    bank_mode_q;
   logic [1:0]    bank_mode_d;
   logic          wr_ptr_q;
   logic          wr_ptr_d;
   logic          rd_ptr_q;
   logic          rd_ptr_d;
   logic [CW-1:0] wr_cnt_q;
   logic [CW-1:0] wr_cnt_d;
   logic [CW-1:0] rd_cnt_q;
   logic [CW-1:0] rd_cnt_d;

   // tile storage: bank, row; deliberately not reset
   logic [ROW_W-1:0] bank_mem_q [2][NUM_PE];

   logic in_fire_s;
   logic out_fire_s;
   logic rd_mode_s;
   logic both_full_s;

   // handshake and status flags derived purely from registered state
   always_comb begin
      in_ready    = (bank_state_q[wr_ptr_q] != BANK_FULL);
      out_valid   = (bank_state_q[rd_ptr_q] == BANK_FULL);
      out_last    = out_valid && (rd_cnt_q == LAST_IDX);
      busy        = (bank_state_q[0] != BANK_EMPTY) || (bank_state_q[1] != BANK_EMPTY);
      both_full_s = (bank_state_q[0] == BANK_FULL) && (bank_state_q[1] == BANK_FULL);
      in_fire_s   = in_valid && in_ready;
      out_fire_s  = out_valid && out_ready;
      rd_mode_s   = bank_mode_q[rd_ptr_q];
   end

   // next-state for bank states, pointers, counters and latched modes
   always_comb begin
      bank_state_d = bank_state_q;
      bank_mode_d  = bank_mode_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      wr_cnt_d     = wr_cnt_q;
      rd_cnt_d     = rd_cnt_q;

      // fill side: the write bank is never the bank being drained, because a
      // drain needs FULL and a FULL write bank blocks input
      if (in_fire_s) begin
         if (wr_cnt_q == ZERO_IDX) begin
            bank_mode_d[wr_ptr_q]  = mode;
            bank_state_d[wr_ptr_q] = BANK_FILLING;
         end else begin
            bank_mode_d[wr_ptr_q]  = bank_mode_q[wr_ptr_q];
         end
         if (wr_cnt_q == LAST_IDX) begin
            bank_state_d[wr_ptr_q] = BANK_FULL;
            wr_cnt_d               = ZERO_IDX;
            wr_ptr_d               = ~wr_ptr_q;
         end else begin
            wr_cnt_d               = wr_cnt_q + ONE_IDX;
         end
      end else begin
         wr_cnt_d = wr_cnt_q;
      end

      // drain side: independent of the fill side so both can complete together
      if (out_fire_s) begin
         if (rd_cnt_q == LAST_IDX) begin
            bank_state_d[rd_ptr_q] = BANK_EMPTY;
            rd_cnt_d               = ZERO_IDX;
            rd_ptr_d               = ~rd_ptr_q;
         end else begin
            rd_cnt_d               = rd_cnt_q + ONE_IDX;
         end
      end else begin
         rd_cnt_d = rd_cnt_q;
      end
   end

   // control registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         bank_state_q[0] <= BANK_EMPTY;
         bank_state_q[1] <= BANK_EMPTY;
         bank_mode_q     <= 2'b00;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         wr_cnt_q        <= ZERO_IDX;
         rd_cnt_q        <= ZERO_IDX;
      end else begin
         bank_state_q    <= bank_state_d;
         bank_mode_q     <= bank_mode_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_cnt_q        <= wr_cnt_d;
         rd_cnt_q        <= rd_cnt_d;
      end
   end

   // row write into the current write bank; reset-gated so a reset edge
   // never lands a row
   always_ff @(posedge clk) begin
      if (rst && in_fire_s) begin
         bank_mem_q[wr_ptr_q][wr_cnt_q] <= in_row;
      end
   end

   // beat assembly: column rd_cnt for transpose, row rd_cnt for pass-through
   always_comb begin
      out_row = {ROW_W{1'b0}};
      for (int e = 0; e < NUM_PE; e++) begin
         logic [CW-1:0] e_idx;
         e_idx = CW'(e);
         if (rd_mode_s) begin
            out_row[e*DATA_WIDTH +: DATA_WIDTH] =
               bank_mem_q[rd_ptr_q][e_idx][int'(rd_cnt_q)*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            out_row[e*DATA_WIDTH +: DATA_WIDTH] =
               bank_mem_q[rd_ptr_q][rd_cnt_q][e*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   transpose_stream_checker u_checker (
      .clk         (clk),
      .rst         (rst),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .busy        (busy),
      .both_full_s (both_full_s)
   );

endmodule

// File: tb/tb_transpose_stream.sv
// tb_transpose_stream: directed and randomised streaming of 4x4 byte tiles,
// checked every cycle against a queue-based tile model plus literal beats.

module tb_transpose_stream;

   localparam int DW = 8;
   localparam int NP = 4;
   localparam int RW = DW * NP;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mode = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [RW-1:0] in_row = '0;
   logic          in_ready;
   logic          out_valid;
   logic          out_last;
   logic          busy;
   logic [RW-1:0] out_row;

   always #5 clk = ~clk;

   transpose_stream #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row    (in_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_last  (out_last),
      .busy      (busy)
   );

   typedef struct packed { logic m; logic [RW-1:0] r; } src_t;
   typedef struct packed { logic [RW-1:0] r; logic l; } beat_t;

   src_t          src_q[$];
   beat_t         exp_q[$];
   logic [RW-1:0] part_rows [NP];
   logic          part_mode = 1'b0;
   int            part_n = 0;
   int            full_tiles = 0;
   bit            in_taken = 1'b0;

   logic [RW-1:0] dut_log[$];
   int            in_cyc[$];
   int            fire_cyc[$];
   int            last_cnt = 0;
   int            cyc = 0;

   int            n_chk = 0;
   int            n_fail = 0;
   bit            check_en = 1'b0;
   int            in_pct = 100;
   int            out_pct = 100;

   task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [RW-1:0] mk_row(input int t, input int r);
      logic [RW-1:0] v;
      for (int e = 0; e < NP; e++) v[e*DW +: DW] = 8'(t*16 + r*4 + e);
      return v;
   endfunction

   task automatic push_tile(input int t, input logic m);
      for (int r = 0; r < NP; r++) src_q.push_back({m, mk_row(t, r)});
   endtask

   task automatic clear_logs();
      dut_log.delete();
      in_cyc.delete();
      fire_cyc.delete();
      last_cnt = 0;
   endtask

   task automatic wait_idle(input string nm, input int bound);
      int k;
      k = 0;
      while ((src_q.size() > 0 || full_tiles > 0 || part_n > 0) && k < bound) begin
         @(posedge clk);
         k++;
      end
      chk(nm, RW'(k < bound), RW'(1));
      @(negedge clk);
   endtask

   // tile model: a tile exists once NP rows are in; its beats come from
   // plain array indexing of the collected rows
   always @(posedge clk) begin
      bit ifire;
      bit ofire;
      cyc++;
      if (!rst) begin
         exp_q.delete();
         part_n     = 0;
         full_tiles = 0;
         in_taken   = 1'b0;
      end else begin
         ifire = in_valid && (full_tiles < 2);
         ofire = out_ready && (full_tiles > 0);
         if (out_valid && out_ready) begin
            dut_log.push_back(out_row);
            fire_cyc.push_back(cyc);
            if (out_last) last_cnt++;
         end
         if (ofire) begin
            if (exp_q[0].l) full_tiles--;
            void'(exp_q.pop_front());
         end
         if (ifire) begin
            if (part_n == 0) part_mode = mode;
            part_rows[part_n] = in_row;
            part_n++;
            in_cyc.push_back(cyc);
            if (src_q.size() > 0) void'(src_q.pop_front());
            if (part_n == NP) begin
               for (int c = 0; c < NP; c++) begin
                  logic [RW-1:0] b;
                  for (int e = 0; e < NP; e++)
                     b[e*DW +: DW] = part_mode ? part_rows[e][c*DW +: DW] : part_rows[c][e*DW +: DW];
                  exp_q.push_back({b, (c == NP-1)});
               end
               full_tiles++;
               part_n = 0;
            end
         end
         in_taken = ifire;
      end
   end

   // input driver: holds a presented row until taken, out_ready by percentage
   initial forever begin
      @(negedge clk);
      if (!(in_valid && !in_taken)) begin
         if (src_q.size() > 0 && rst && ($urandom_range(99) < in_pct)) begin
            in_valid = 1'b1;
            in_row   = src_q[0].r;
            mode     = src_q[0].m;
         end else begin
            in_valid = 1'b0;
         end
      end
      out_ready = ($urandom_range(99) < out_pct);
   end

   // per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (check_en) begin
         chk("out_valid", RW'(out_valid), RW'(full_tiles > 0));
         chk("in_ready", RW'(in_ready), RW'(full_tiles < 2));
         chk("busy", RW'(busy), RW'((full_tiles > 0) || (part_n > 0)));
         if (full_tiles > 0) begin
            chk("out_row", out_row, exp_q[0].r);
            chk("out_last", RW'(out_last), RW'(exp_q[0].l));
         end else begin
            chk("out_last_idle", RW'(out_last), RW'(0));
         end
      end
   end

   initial begin
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check_en = 1'b1;
      chk("reset_in_ready", RW'(in_ready), RW'(1));
      chk("reset_out_valid", RW'(out_valid), RW'(0));
      chk("reset_busy", RW'(busy), RW'(0));

      // transpose of the reference tile
      clear_logs();
      src_q.push_back({1'b1, 32'h03020100});
      src_q.push_back({1'b1, 32'h13121110});
      src_q.push_back({1'b1, 32'h23222120});
      src_q.push_back({1'b1, 32'h33323130});
      wait_idle("s1_idle", 200);
      chk("s1_beat0", dut_log[0], 32'h30201000);
      chk("s1_beat1", dut_log[1], 32'h31211101);
      chk("s1_beat2", dut_log[2], 32'h32221202);
      chk("s1_beat3", dut_log[3], 32'h33231303);
      chk("s1_latency", RW'(fire_cyc[0] - in_cyc[3]), RW'(1));
      chk("s1_last_cnt", RW'(last_cnt), RW'(1));

      // pass-through of the same tile
      clear_logs();
      src_q.push_back({1'b0, 32'h03020100});
      src_q.push_back({1'b0, 32'h13121110});
      src_q.push_back({1'b0, 32'h23222120});
      src_q.push_back({1'b0, 32'h33323130});
      wait_idle("s2_idle", 200);
      chk("s2_beat0", dut_log[0], 32'h03020100);
      chk("s2_beat3", dut_log[3], 32'h33323130);

      // three tiles against a stalled consumer
      clear_logs();
      out_pct = 0;
      push_tile(0, 1'b1);
      push_tile(1, 1'b0);
      push_tile(2, 1'b1);
      repeat (20) @(negedge clk);
      chk("s3_rows_taken", RW'(in_cyc.size()), RW'(8));
      chk("s3_in_ready_low", RW'(in_ready), RW'(0));
      out_pct = 100;
      wait_idle("s3_idle", 300);
      chk("s3_beats", RW'(dut_log.size()), RW'(12));
      chk("s3_t0_beat0", dut_log[0], 32'h0C080400);
      chk("s3_t1_beat0", dut_log[4], 32'h13121110);
      chk("s3_t2_beat3", dut_log[11], 32'h2F2B2723);

      // continuous stream, mode flipped mid-tile A
      clear_logs();
      src_q.push_back({1'b1, mk_row(1, 0)});
      src_q.push_back({1'b1, mk_row(1, 1)});
      src_q.push_back({1'b0, mk_row(1, 2)});
      src_q.push_back({1'b0, mk_row(1, 3)});
      push_tile(2, 1'b0);
      wait_idle("s4_idle", 300);
      chk("s4_A_beat0", dut_log[0], 32'h1C181410);
      chk("s4_B_beat0", dut_log[4], 32'h23222120);
      chk("s4_in_no_bubble", RW'(in_cyc[7] - in_cyc[0]), RW'(7));
      chk("s4_out_no_bubble", RW'(fire_cyc[7] - fire_cyc[0]), RW'(7));

      // random handshakes over 100 tiles
      clear_logs();
      in_pct = 50;
      out_pct = 50;
      for (int t = 0; t < 100; t++) begin
         logic m;
         m = 1'($urandom_range(1));
         for (int r = 0; r < NP; r++) src_q.push_back({m, RW'($urandom)});
      end
      wait_idle("s5_idle", 20000);
      chk("s5_last_cnt", RW'(last_cnt), RW'(100));
      chk("s5_beats", RW'(dut_log.size()), RW'(400));

      // reset with one full bank and a partial tile in the other
      clear_logs();
      in_pct = 100;
      out_pct = 0;
      push_tile(5, 1'b1);
      src_q.push_back({1'b1, mk_row(6, 0)});
      src_q.push_back({1'b1, mk_row(6, 1)});
      begin
         int k;
         k = 0;
         while (src_q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
         end
         chk("s6_fill", RW'(k < 100), RW'(1));
      end
      repeat (2) @(negedge clk);
      chk("s6_pre_busy", RW'(busy), RW'(1));
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("s6_post_out_valid", RW'(out_valid), RW'(0));
      chk("s6_post_busy", RW'(busy), RW'(0));
      clear_logs();
      out_pct = 100;
      push_tile(7, 1'b1);
      wait_idle("s6_idle", 200);
      chk("s6_beats", RW'(dut_log.size()), RW'(4));
      chk("s6_beat0", dut_log[0], 32'h7C787470);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
